// File: rtl/dmem_arbiter.sv
// Two-port arbiter that lets the core and the loader share one single-ported data memory.
// A single transaction is in flight at a time; when both ports request together, round-robin decides.
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_ack,
   output logic              c_stall,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;          // 1 = loader
   logic              last_grant_q, last_grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              sel_l;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      rdata_d      = rdata_q;
      // Loader wins when it is alone, or on a tie when the core was served last.
      sel_l        = l_req & (~c_req | ~last_grant_q);
      unique case (state_q)
         StIdle: begin
            if (c_req || l_req) begin
               grant_d = sel_l;
               we_d    = sel_l ? l_we    : c_we;
               addr_d  = sel_l ? l_addr  : c_addr;
               wdata_d = sel_l ? l_wdata : c_wdata;
               err_d   = (addr_d[2:0] != 3'b000);
               state_d = err_d ? StResp : StAccess;
            end
         end
         StAccess: begin
            if (!we_q) rdata_d = mem_rdata;
            state_d = StResp;
         end
         StResp: begin
            last_grant_d = grant_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q != StIdle);
      c_ack     = (state_q == StResp) & ~grant_q;
      l_ack     = (state_q == StResp) & grant_q;
      err       = (state_q == StResp) & err_q;
      mem_write = (state_q == StAccess) & we_q;
      mem_read  = (state_q == StAccess) & ~we_q;
      mem_addr  = (state_q == StAccess) ? addr_q  : '0;
      mem_wdata = (state_q == StAccess) ? wdata_q : '0;
      rdata     = rdata_q;
      c_stall   = c_req & ~c_ack;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-port expectation queues, a forked monitor
// and a transaction-level memory model that is updated in ack order.
module tb_dmem_arbiter;

   logic        clk, reset;
   logic        c_req, c_we, l_req, l_we;
   logic [63:0] c_addr, c_wdata, l_addr, l_wdata;
   logic        c_ack, c_stall, l_ack, err, mem_write, mem_read, busy;
   logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;

   logic [63:0] mem [32];
   logic [63:0] model_mem [32];

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          start;
   } txn_t;

   txn_t qc[$];
   txn_t ql[$];
   bit   ack_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_stall(c_stall),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_ack(l_ack), .rdata(rdata), .err(err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   // Data memory stand-in: combinational read, write on the clock edge.
   assign mem_rdata = mem[mem_addr[7:3]];
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      mem[2] = 64'hDEAD;
      forever begin
         @(posedge clk);
         if (mem_write) mem[mem_addr[7:3]] = mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit p, input bit we, input logic [63:0] a, input logic [63:0] d,
                        input bit hold, output int lat);
      txn_t t;
      int   n;
      bit   got;
      t.we = we; t.addr = a; t.wdata = d; t.start = cycle;
      if (p) begin
         l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d; ql.push_back(t);
      end else begin
         c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d; qc.push_back(t);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         got = p ? l_ack : c_ack;
      end while (!got && n < 20);
      lat = cycle - t.start;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ack_timeout: port %0d got no ack within %0d cycles", p, n);
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         if (p) l_req = 1'b0;
         else   c_req = 1'b0;
      end
   endtask

   task automatic monitor();
      txn_t        t;
      int          mem_cycles = 0;
      logic [63:0] m_addr = '0, m_wdata = '0;
      logic        m_we = 1'b0;
      bit          p, bad;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mem_cycles = 0;
         end else begin
            chk("ack_exclusive", 64'(c_ack & l_ack), 64'd0);
            chk("c_stall", 64'(c_stall), 64'(c_req & ~c_ack));
            if (mem_write || mem_read) begin
               mem_cycles++;
               m_addr = mem_addr; m_we = mem_write; m_wdata = mem_wdata;
               chk("rw_exclusive", 64'(mem_write & mem_read), 64'd0);
            end else begin
               chk("mem_addr_idle", mem_addr, 64'd0);
               chk("mem_wdata_idle", mem_wdata, 64'd0);
            end
            if (c_ack || l_ack) begin
               p = l_ack;
               chk("busy_resp", 64'(busy), 64'd1);
               checks++;
               if ((p && ql.size() == 0) || (!p && qc.size() == 0)) begin
                  errors++;
                  $display("FAIL ack_unexpected: port %0d acked with nothing outstanding", p);
               end else begin
                  t = p ? ql.pop_front() : qc.pop_front();
                  bad = (t.addr[2:0] != 3'b000);
                  chk("err", 64'(err), 64'(bad));
                  chk("mem_cycles", 64'(mem_cycles), bad ? 64'd0 : 64'd1);
                  if (!bad) begin
                     chk("mem_addr", m_addr, t.addr);
                     chk("mem_dir", 64'(m_we), 64'(t.we));
                     if (t.we) begin
                        chk("mem_wdata", m_wdata, t.wdata);
                        model_mem[t.addr[7:3]] = t.wdata;
                     end else begin
                        chk("rdata", rdata, model_mem[t.addr[7:3]]);
                     end
                  end
                  chk("wait_bound", 64'(cycle - t.start <= 5), 64'd1);
               end
               ack_log.push_back(p);
               mem_cycles = 0;
            end else begin
               chk("err_idle", 64'(err), 64'd0);
            end
         end
      end
   endtask

   task automatic port_loop(input bit p, input int n, input bit rnd);
      int          lat;
      bit          hold;
      bit          we;
      logic [63:0] a, d;
      for (int i = 0; i < n; i++) begin
         we = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         a  = {$urandom, $urandom};
         a[2:0] = ($urandom_range(0, 5) == 0 && rnd) ? 3'($urandom_range(1, 7)) : 3'd0;
         d  = {$urandom, $urandom};
         hold = (i < n - 1) && (!rnd || $urandom_range(0, 2) == 0);
         drive(p, we, a, d, hold, lat);
         if (!hold && rnd) repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
   endtask

   int lc, ll;

   initial begin
      for (int i = 0; i < 32; i++) model_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      model_mem[2] = 64'hDEAD;
      reset = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
      #2;
      chk("rst_c_ack", 64'(c_ack), 64'd0);
      chk("rst_l_ack", 64'(l_ack), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_rw", 64'({mem_write, mem_read}), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      fork
         monitor();
      join_none
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk); #1;

      // Core load at 0x10 reads 0xDEAD; aligned latency.
      drive(1'b0, 1'b0, 64'h10, 64'h0, 1'b0, lc);
      chk("lat_core_load", 64'(lc), 64'd2);
      // Loader store to 0x8, then read it back from the core.
      drive(1'b1, 1'b1, 64'h8, 64'h5, 1'b0, ll);
      chk("lat_loader_store", 64'(ll), 64'd2);
      drive(1'b0, 1'b0, 64'h8, 64'h0, 1'b0, lc);
      chk("readback_rdata", rdata, 64'h5);
      // Misaligned core request.
      drive(1'b0, 1'b0, 64'h3, 64'h0, 1'b0, lc);
      chk("lat_misaligned", 64'(lc), 64'd1);

      // Reset in the middle of a store's memory cycle.
      l_req = 1'b1; l_we = 1'b1; l_addr = 64'h18; l_wdata = 64'h77;
      @(posedge clk); #1;
      chk("abort_mem_write_before", 64'(mem_write), 64'd1);
      l_req = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("abort_mem_write_after", 64'(mem_write), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_l_ack", 64'(l_ack), 64'd0);
      @(posedge clk); #2 reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_ack", 64'(l_ack | c_ack), 64'd0);
         chk("abort_idle", 64'(busy), 64'd0);
      end
      chk("abort_no_store", mem[3], model_mem[3]);

      // Reset leaves the loader as last grant, so the core wins the first tie.
      @(posedge clk); #1;
      fork
         drive(1'b0, 1'b0, 64'h20, 64'h0, 1'b0, lc);
         drive(1'b1, 1'b0, 64'h28, 64'h0, 1'b0, ll);
      join
      chk("tie1_core_lat", 64'(lc), 64'd2);
      chk("tie1_loader_lat", 64'(ll), 64'd5);
      fork
         drive(1'b0, 1'b1, 64'h30, 64'h1234, 1'b0, lc);
         drive(1'b1, 1'b0, 64'h30, 64'h0, 1'b0, ll);
      join
      chk("tie2_core_lat", 64'(lc), 64'd2);
      chk("tie2_loader_lat", 64'(ll), 64'd5);

      // Continuous requests from both ports must alternate strictly.
      ack_log.delete();
      fork
         port_loop(1'b0, 3, 1'b0);
         port_loop(1'b1, 3, 1'b0);
      join
      chk("alt_count", 64'(ack_log.size()), 64'd6);
      for (int i = 0; i < ack_log.size() && i < 6; i++)
         chk($sformatf("alt_order_%0d", i), 64'(ack_log[i]), 64'(i % 2));

      // Randomised traffic on both ports.
      fork
         port_loop(1'b0, 40, 1'b1);
         port_loop(1'b1, 40, 1'b1);
      join
      repeat (4) @(posedge clk);
      chk("queues_drained", 64'(qc.size() + ql.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
